// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
// One conditional add and one right shift of {A,Q} per clock over WL iterations.
module shift_add_multiplier #(
   parameter int WL = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [WL-1:0]   multiplicand,
   input  logic [WL-1:0]   multiplier,
   output logic [2*WL-1:0] product,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(WL) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WL-1:0]     m_q, m_d;
   logic [WL:0]       a_q, a_d;
   logic [WL-1:0]     q_q, q_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*WL-1:0]   product_q, product_d;
   logic [WL:0]       sum;
   logic              last_iter;

   // A is WL+1 bits wide, so the add can never overflow
   assign sum       = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
   assign last_iter = (cnt_q == CW'(WL - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_iter) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   always_comb begin
      m_d       = m_q;
      a_d       = a_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d   = multiplicand;
               q_d   = multiplier;
               a_d   = '0;
               cnt_d = '0;
            end
         end
         S_RUN: begin
            a_d   = {1'b0, sum[WL:1]};
            q_d   = {sum[0], q_q[WL-1:1]};
            cnt_d = cnt_q + CW'(1);
            // Post-shift {A,Q} minus its always-zero top bit
            if (last_iter) begin
               product_d = {sum, q_q[WL-1:1]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         m_q       <= m_d;
         a_q       <= a_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
// Table-driven vectors at WL=4 plus handshake corner cases and a WL=8 sweep.
module tb_shift_add_multiplier;

   logic        CLK;
   logic        RST;
   logic        start4, busy4, done4;
   logic [3:0]  m4, q4;
   logic [7:0]  product4;
   logic        start8, busy8, done8;
   logic [7:0]  m8, q8;
   logic [15:0] product8;

   int n_checks;
   int n_pass;

   shift_add_multiplier #(.WL(4)) u_dut4 (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start4),
      .multiplicand (m4),
      .multiplier   (q4),
      .product      (product4),
      .busy         (busy4),
      .done         (done4)
   );

   shift_add_multiplier #(.WL(8)) u_dut8 (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start8),
      .multiplicand (m8),
      .multiplier   (q8),
      .product      (product8),
      .busy         (busy8),
      .done         (done8)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] m;
      logic [3:0] q;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Accept edge is edge 0; counts edges until done is seen
   task automatic wait_done4(output int lat);
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic wait_done8(output int lat);
      lat = 0;
      while (done8 !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   int          lat;
   int          seen_done;
   logic [15:0] exp16;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      vecs[0] = '{m: 4'd13, q: 4'd11, p: 8'h8F};
      vecs[1] = '{m: 4'd15, q: 4'd15, p: 8'hE1};
      vecs[2] = '{m: 4'd0,  q: 4'd9,  p: 8'h00};
      vecs[3] = '{m: 4'd1,  q: 4'd15, p: 8'h0F};
      vecs[4] = '{m: 4'd0,  q: 4'd0,  p: 8'h00};
      vecs[5] = '{m: 4'd9,  q: 4'd7,  p: 8'h3F};
      vecs[6] = '{m: 4'd8,  q: 4'd2,  p: 8'h10};
      vecs[7] = '{m: 4'd15, q: 4'd1,  p: 8'h0F};

      RST = 1'b0; start4 = 1'b0; start8 = 1'b0;
      m4 = '0; q4 = '0; m8 = '0; q8 = '0;
      repeat (3) tick();
      RST = 1'b1;

      // Scenario 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         check("reset_product", 32'(product4), 32'h0);
         check("reset_busy",    32'(busy4),    32'h0);
         check("reset_done",    32'(done4),    32'h0);
      end

      // Scenario 2: 13*11 cycle-accurate timing
      m4 = 4'd13; q4 = 4'd11; start4 = 1'b1;
      tick();
      start4 = 1'b0; m4 = 4'd2; q4 = 4'd2;
      check("s2_busy_edge0", 32'(busy4), 32'h1);
      check("s2_done_edge0", 32'(done4), 32'h0);
      for (int e = 1; e <= 3; e++) begin
         tick();
         check("s2_busy_run", 32'(busy4), 32'h1);
         check("s2_done_run", 32'(done4), 32'h0);
      end
      tick();
      check("s2_done_edge4",    32'(done4),    32'h1);
      check("s2_busy_edge4",    32'(busy4),    32'h1);
      check("s2_product_edge4", 32'(product4), 32'h8F);
      tick();
      check("s2_done_edge5",    32'(done4),    32'h0);
      check("s2_busy_edge5",    32'(busy4),    32'h0);
      check("s2_product_hold",  32'(product4), 32'h8F);
      tick();

      // Table-driven vectors with latency check
      for (int i = 0; i < 8; i++) begin
         m4 = vecs[i].m; q4 = vecs[i].q; start4 = 1'b1;
         tick();
         start4 = 1'b0; m4 = ~vecs[i].m; q4 = ~vecs[i].q;
         wait_done4(lat);
         check($sformatf("vec%0d_product", i), 32'(product4), 32'(vecs[i].p));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         tick();
         tick();
      end

      // Scenario 3: start held high, back-to-back
      m4 = 4'd15; q4 = 4'd15; start4 = 1'b1;
      tick();
      m4 = 4'd0; q4 = 4'd9;
      wait_done4(lat);
      check("s3_first_product", 32'(product4), 32'hE1);
      check("s3_first_latency", 32'(lat), 32'd4);
      tick();
      check("s3_done_is_pulse", 32'(done4), 32'h0);
      check("s3_idle_busy",     32'(busy4), 32'h0);
      tick();
      check("s3_second_accept", 32'(busy4), 32'h1);
      m4 = 4'd1; q4 = 4'd15;
      wait_done4(lat);
      check("s3_second_product", 32'(product4), 32'h00);
      check("s3_done_spacing",   32'(lat + 2), 32'd6);
      tick();
      tick();
      m4 = 4'd3; q4 = 4'd3;
      wait_done4(lat);
      check("s3_third_product", 32'(product4), 32'h0F);
      check("s3_done_spacing3", 32'(lat + 2), 32'd6);
      start4 = 1'b0;
      tick();
      tick();

      // Scenario 4: start ignored while busy
      m4 = 4'd13; q4 = 4'd11; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      m4 = 4'd7; q4 = 4'd3; start4 = 1'b1;
      tick();
      tick();
      tick();
      start4 = 1'b0;
      check("s4_done_on_time",  32'(done4),    32'h1);
      check("s4_product",       32'(product4), 32'h8F);
      tick();
      tick();

      // Scenario 5: reset mid-RUN
      m4 = 4'd15; q4 = 4'd15; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      check("s5_busy_after_rst",    32'(busy4),    32'h0);
      check("s5_product_after_rst", 32'(product4), 32'h0);
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         if (done4 === 1'b1) seen_done++;
         tick();
      end
      check("s5_no_done", 32'(seen_done), 32'h0);
      m4 = 4'd5; q4 = 4'd6; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      wait_done4(lat);
      check("s5_after_product", 32'(product4), 32'h1E);
      tick();
      tick();

      // Scenario 6: WL=8 corner plus random sweep
      m8 = 8'd255; q8 = 8'd255; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait_done8(lat);
      check("w8_max_product", 32'(product8), 32'hFE01);
      check("w8_max_latency", 32'(lat), 32'd8);
      tick();
      tick();
      for (int i = 0; i < 500; i++) begin
         m8 = 8'($urandom_range(0, 255));
         q8 = 8'($urandom_range(0, 255));
         exp16 = 16'(m8) * 16'(q8);
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
         m8 = 8'($urandom_range(0, 255));
         q8 = 8'($urandom_range(0, 255));
         wait_done8(lat);
         check($sformatf("w8_rand%0d", i), 32'(product8), 32'(exp16));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
